// File: rtl/pattern_stream_serializer_if.sv
// Word-in / bit-out bundle between a word source and the serializer.
// master drives words and observes the serial side; slave is the serializer.
interface pattern_stream_serializer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  sout,
        input  sout_valid,
        input  busy,
        input  word_cnt
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output sout,
        output sout_valid,
        output busy,
        output word_cnt
    );
endinterface

// File: rtl/pattern_stream_serializer.sv
// Parallel-to-serial feeder: one-word holding buffer plus shift register, one bit per clock.
// Latency: accept at edge N, first bit after edge N+1; gapless while the buffer is refilled in time.
// Backpressure: din_ready drops while the holding buffer is full or reset is asserted.
module pattern_stream_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   LSB_FIRST = 0,
    parameter logic IDLE_BIT  = 1'b0,
    parameter int   CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        rest,
    pattern_stream_serializer_if.slave  bus
);
    localparam int BCNT_W = $clog2(WIDTH);
    localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_hbuf;
    logic               r_hfull;
    logic [WIDTH-1:0]   r_sreg;
    logic [BCNT_W-1:0]  r_bcnt;
    logic [CNT_W-1:0]   r_word_cnt;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_hbuf_nxt;
    logic               w_hfull_nxt;
    logic [WIDTH-1:0]   w_sreg_nxt;
    logic [BCNT_W-1:0]  w_bcnt_nxt;
    logic [CNT_W-1:0]   w_word_cnt_nxt;

    logic               w_din_ready;
    logic               w_accept;
    logic               w_out_bit;
    logic [WIDTH-1:0]   w_sreg_shifted;

    // Shift direction moves the next bit toward the tapped end; vacated bits fill with zero.
    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign w_out_bit      = r_sreg[0];
            assign w_sreg_shifted = r_sreg >> 1;
        end else begin : g_msb
            assign w_out_bit      = r_sreg[WIDTH-1];
            assign w_sreg_shifted = r_sreg << 1;
        end
    endgenerate

    assign w_din_ready = !r_hfull && !rest;
    assign w_accept    = bus.din_valid && w_din_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_hbuf_nxt     = r_hbuf;
        w_hfull_nxt    = r_hfull;
        w_sreg_nxt     = r_sreg;
        w_bcnt_nxt     = r_bcnt;
        w_word_cnt_nxt = r_word_cnt;

        case (r_state)
            S_IDLE: begin
                if (r_hfull) begin
                    w_sreg_nxt  = r_hbuf;
                    w_hfull_nxt = 1'b0;
                    w_bcnt_nxt  = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_sreg_nxt = w_sreg_shifted;
                w_bcnt_nxt = r_bcnt + 1'b1;
                if (r_bcnt == LAST_IDX) begin
                    w_word_cnt_nxt = r_word_cnt + 1'b1;
                    if (r_hfull) begin
                        w_sreg_nxt  = r_hbuf;
                        w_hfull_nxt = 1'b0;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // An accept only happens with the buffer empty, so it never races the reload above.
        if (w_accept) begin
            w_hbuf_nxt  = bus.din;
            w_hfull_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            r_state    <= S_IDLE;
            r_hbuf     <= '0;
            r_hfull    <= 1'b0;
            r_sreg     <= '0;
            r_bcnt     <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hbuf     <= w_hbuf_nxt;
            r_hfull    <= w_hfull_nxt;
            r_sreg     <= w_sreg_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_word_cnt <= w_word_cnt_nxt;
        end
    end

    assign bus.din_ready  = w_din_ready;
    assign bus.sout       = (r_state == S_SHIFT) ? w_out_bit : IDLE_BIT;
    assign bus.sout_valid = (r_state == S_SHIFT);
    assign bus.busy       = (r_state == S_SHIFT) || r_hfull;
    assign bus.word_cnt   = r_word_cnt;

endmodule

// File: tb/tb_pattern_stream_serializer.sv
module tb_pattern_stream_serializer;
    logic clk  = 1'b0;
    logic rest = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // 0: default MSB-first, 1: LSB-first, 2: 2-bit word counter
    pattern_stream_serializer_if #(.WIDTH(8), .CNT_W(8)) ifa ();
    pattern_stream_serializer_if #(.WIDTH(8), .CNT_W(8)) ifl ();
    pattern_stream_serializer_if #(.WIDTH(8), .CNT_W(2)) ifc ();

    pattern_stream_serializer #(.WIDTH(8), .LSB_FIRST(0), .IDLE_BIT(1'b0), .CNT_W(8))
        dut_a (.clk(clk), .rest(rest), .bus(ifa.slave));
    pattern_stream_serializer #(.WIDTH(8), .LSB_FIRST(1), .IDLE_BIT(1'b0), .CNT_W(8))
        dut_l (.clk(clk), .rest(rest), .bus(ifl.slave));
    pattern_stream_serializer #(.WIDTH(8), .LSB_FIRST(0), .IDLE_BIT(1'b0), .CNT_W(2))
        dut_c (.clk(clk), .rest(rest), .bus(ifc.slave));

    logic [7:0] t_din [3];
    logic       t_vld [3];
    logic       o_rdy [3];
    logic       o_sout[3];
    logic       o_svld[3];
    logic       o_busy[3];
    logic [7:0] o_cnt [3];

    assign ifa.din = t_din[0];  assign ifa.din_valid = t_vld[0];
    assign ifl.din = t_din[1];  assign ifl.din_valid = t_vld[1];
    assign ifc.din = t_din[2];  assign ifc.din_valid = t_vld[2];

    assign o_rdy[0] = ifa.din_ready;  assign o_sout[0] = ifa.sout;
    assign o_svld[0] = ifa.sout_valid; assign o_busy[0] = ifa.busy;
    assign o_cnt[0] = ifa.word_cnt;
    assign o_rdy[1] = ifl.din_ready;  assign o_sout[1] = ifl.sout;
    assign o_svld[1] = ifl.sout_valid; assign o_busy[1] = ifl.busy;
    assign o_cnt[1] = ifl.word_cnt;
    assign o_rdy[2] = ifc.din_ready;  assign o_sout[2] = ifc.sout;
    assign o_svld[2] = ifc.sout_valid; assign o_busy[2] = ifc.busy;
    assign o_cnt[2] = {6'b0, ifc.word_cnt};

    typedef struct {
        int         sel;
        logic [7:0] word;
        logic [7:0] bits;   // expected serial order, bits[7] appears first
        logic [7:0] cnt;    // word_cnt after the word has fully shifted
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic stream_one(input int sel, input logic [7:0] w);
        int k;
        t_din[sel] = w;
        t_vld[sel] = 1'b1;
        k = 0;
        while (!o_rdy[sel] && k < 50) begin tick(); k++; end
        tick();
        t_vld[sel] = 1'b0;
        k = 0;
        while (o_busy[sel] && k < 50) begin tick(); k++; end
        chk("stream_timeout", {31'b0, k < 50}, 32'd1);
    endtask

    logic [15:0] pair_bits;
    int          nvalid;

    initial begin
        tbl[0] = '{0, 8'hD5, 8'b1101_0101, 8'd1};
        tbl[1] = '{0, 8'h35, 8'b0011_0101, 8'd2};
        tbl[2] = '{0, 8'h00, 8'b0000_0000, 8'd3};
        tbl[3] = '{0, 8'hFF, 8'b1111_1111, 8'd4};
        tbl[4] = '{0, 8'h81, 8'b1000_0001, 8'd5};
        tbl[5] = '{1, 8'hAB, 8'b1101_0101, 8'd1};
        tbl[6] = '{1, 8'h80, 8'b0000_0001, 8'd2};

        for (int s = 0; s < 3; s++) begin
            t_din[s] = 8'hFF;
            t_vld[s] = 1'b1;
        end

        // Reset held two cycles with a word offered
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_ready", {31'b0, o_rdy[0]}, 32'd0);
            chk("rst_sout",  {31'b0, o_sout[0]}, 32'd0);
            chk("rst_svld",  {31'b0, o_svld[0]}, 32'd0);
            chk("rst_busy",  {31'b0, o_busy[0]}, 32'd0);
        end
        chk("rst_cnt", {24'b0, o_cnt[0]}, 32'd0);
        rest = 1'b0;
        #1;
        chk("rel_ready", {31'b0, o_rdy[0]}, 32'd1);
        chk("rel_busy",  {31'b0, o_busy[0]}, 32'd0);
        for (int s = 0; s < 3; s++) t_vld[s] = 1'b0;
        tick();
        chk("rel_nothing_accepted", {31'b0, o_busy[0]}, 32'd0);

        // Single words, one at a time
        for (int v = 0; v < 7; v++) begin
            int s;
            s = tbl[v].sel;
            chk("tbl_ready_pre", {31'b0, o_rdy[s]}, 32'd1);
            t_din[s] = tbl[v].word;
            t_vld[s] = 1'b1;
            tick();
            t_vld[s] = 1'b0;
            chk("tbl_wait_svld", {31'b0, o_svld[s]}, 32'd0);
            chk("tbl_wait_busy", {31'b0, o_busy[s]}, 32'd1);
            tick();
            for (int b = 7; b >= 0; b--) begin
                chk("tbl_svld", {31'b0, o_svld[s]}, 32'd1);
                chk("tbl_bit",  {31'b0, o_sout[s]}, {31'b0, tbl[v].bits[b]});
                tick();
            end
            chk("tbl_idle_svld", {31'b0, o_svld[s]}, 32'd0);
            chk("tbl_idle_sout", {31'b0, o_sout[s]}, 32'd0);
            chk("tbl_idle_busy", {31'b0, o_busy[s]}, 32'd0);
            chk("tbl_cnt",       {24'b0, o_cnt[s]}, {24'b0, tbl[v].cnt});
        end

        // Back-to-back D5 then 35: gapless 16 bits
        pair_bits = 16'b1101_0101_0011_0101;
        t_din[0] = 8'hD5;
        t_vld[0] = 1'b1;
        tick();
        chk("b2b_ready_full", {31'b0, o_rdy[0]}, 32'd0);
        t_din[0] = 8'h35;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("b2b_svld", {31'b0, o_svld[0]}, 32'd1);
            chk("b2b_bit",  {31'b0, o_sout[0]}, {31'b0, pair_bits[15-i]});
            if (i == 0)                 chk("b2b_ready_open", {31'b0, o_rdy[0]}, 32'd1);
            else if (i >= 1 && i <= 7)  chk("b2b_ready_held", {31'b0, o_rdy[0]}, 32'd0);
            else if (i == 8)            chk("b2b_ready_again", {31'b0, o_rdy[0]}, 32'd1);
            tick();
            if (i == 0) t_vld[0] = 1'b0;
        end
        chk("b2b_end_svld", {31'b0, o_svld[0]}, 32'd0);
        chk("b2b_end_busy", {31'b0, o_busy[0]}, 32'd0);
        chk("b2b_cnt",      {24'b0, o_cnt[0]}, 32'd7);

        // Reset after three bits of D5 with 35 buffered
        t_din[0] = 8'hD5;
        t_vld[0] = 1'b1;
        tick();
        t_din[0] = 8'h35;
        tick();
        tick();
        t_vld[0] = 1'b0;
        chk("mid_buffered", {31'b0, o_rdy[0]}, 32'd0);
        tick();
        chk("mid_svld_pre", {31'b0, o_svld[0]}, 32'd1);
        rest = 1'b1;
        tick();
        chk("mid_rst_svld", {31'b0, o_svld[0]}, 32'd0);
        chk("mid_rst_busy", {31'b0, o_busy[0]}, 32'd0);
        chk("mid_rst_cnt",  {24'b0, o_cnt[0]}, 32'd0);
        chk("mid_rst_rdy",  {31'b0, o_rdy[0]}, 32'd0);
        rest = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_svld[0] || o_busy[0]) nvalid++;
            tick();
        end
        chk("mid_no_residue", nvalid, 32'd0);
        chk("mid_cnt_after",  {24'b0, o_cnt[0]}, 32'd0);

        // Two-bit counter wraps
        stream_one(2, 8'h12); chk("wrap_cnt1", {24'b0, o_cnt[2]}, 32'd1);
        stream_one(2, 8'h34); chk("wrap_cnt2", {24'b0, o_cnt[2]}, 32'd2);
        stream_one(2, 8'h56); chk("wrap_cnt3", {24'b0, o_cnt[2]}, 32'd3);
        stream_one(2, 8'h78); chk("wrap_cnt0", {24'b0, o_cnt[2]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
